// File: rtl/ghost_collision_detector_pkg.sv
// Shared types for the ghost collision detector.
// ghost_modes_t mirrors the ghost AI modes; the FSM enums belong to the detector.
package ghost_collision_detector_pkg;

  typedef enum logic [1:0] {
    CHASE   = 2'd0,
    SCATTER = 2'd1,
    AFFRAID = 2'd2,
    EATEN   = 2'd3
  } ghost_modes_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } coll_fsm_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } report_fsm_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int count_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ghost_collision_detector_overlap_counter.sv
// Saturating per-ghost overlap counter.
// hit reflects the value the counter would take this cycle, so the pixel
// sampled on the clearing edge still contributes to the verdict.
module overlap_counter
  import ghost_collision_detector_pkg::*;
#(
  parameter int MIN_OVERLAP = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CW = count_width(MIN_OVERLAP);
  localparam logic [CW-1:0] LIMIT = CW'(MIN_OVERLAP);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next count: increment on an overlapping pixel, stick at the threshold.
  always_comb begin
    cnt_next = cnt;
    if (inc && (cnt < LIMIT)) begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign hit = (cnt_next >= LIMIT);

  // Count register; clearing wins so every frame starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/ghost_collision_detector.sv
// Pixel-level pacman/ghost collision detector.
// Counts overlapping pixels per ghost over one frame, classifies hits at end
// of frame as eat or kill, and hands one report per frame over valid/ready.
// Optional feature macro: COLL_STATS_EN adds the stat_reports accept counter.
module ghost_collision_detector
  import ghost_collision_detector_pkg::*;
#(
  parameter int NUM_GHOSTS  = 4,
  parameter int MIN_OVERLAP = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pixel_tick,
  input  logic                          video_on,
  input  logic [9:0]                    h_count,
  input  logic [9:0]                    v_count,
  input  logic                          pacman_drawing,
  input  logic [NUM_GHOSTS-1:0]         ghost_drawing,
  input  ghost_modes_t [NUM_GHOSTS-1:0] ghost_state,
  output logic                          coll_valid,
  input  logic                          coll_ready,
  output logic [NUM_GHOSTS-1:0]         coll_eat_mask,
  output logic                          coll_kill,
  output logic                          coll_overrun
`ifdef COLL_STATS_EN
  ,
  output logic [15:0]                   stat_reports
`endif
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  coll_fsm_t   coll_state;
  report_fsm_t rpt_state;

  logic                  qualified;
  logic                  sof;
  logic                  eof;
  logic                  counting;
  logic                  frame_end;
  logic                  accept;
  logic                  any_new;
  logic                  kill_new;
  logic [NUM_GHOSTS-1:0] eat_new;
  logic [NUM_GHOSTS-1:0] inc;
  logic [NUM_GHOSTS-1:0] hit;

  assign qualified = pixel_tick & video_on;
  assign sof       = qualified & (h_count == 10'd0) & (v_count == 10'd0);
  assign eof       = qualified & (h_count == H_LAST) & (v_count == V_LAST);
  // The start-of-frame pixel belongs to the frame it opens.
  assign counting  = qualified & ((coll_state == ACCUM) | sof);
  assign frame_end = eof & (coll_state == ACCUM);
  assign accept    = coll_valid & coll_ready;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_counter
    assign inc[g] = counting & pacman_drawing & ghost_drawing[g];

    overlap_counter #(
      .MIN_OVERLAP(MIN_OVERLAP)
    ) u_counter (
      .clk    (clk),
      .reset_n(reset_n),
      .inc    (inc[g]),
      .clr    (eof),
      .hit    (hit[g])
    );
  end

  // End-of-frame verdict per ghost, using the mode the ghost is in right now.
  always_comb begin
    eat_new  = '0;
    kill_new = 1'b0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (frame_end && hit[i]) begin
        case (ghost_state[i])
          AFFRAID: eat_new[i] = 1'b1;
          EATEN:   ;
          default: kill_new = 1'b1;
        endcase
      end
    end
  end

  assign any_new = (|eat_new) | kill_new;

  // Frame alignment: ignore whatever partial frame follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_state <= WAIT_SOF;
    end else if ((coll_state == WAIT_SOF) && sof) begin
      coll_state <= ACCUM;
    end
  end

  // Report hand-off: load, merge on overrun, retire on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_state     <= IDLE;
      coll_valid    <= 1'b0;
      coll_eat_mask <= '0;
      coll_kill     <= 1'b0;
      coll_overrun  <= 1'b0;
    end else begin
      case (rpt_state)
        IDLE: begin
          if (any_new) begin
            rpt_state     <= PEND;
            coll_valid    <= 1'b1;
            coll_eat_mask <= eat_new;
            coll_kill     <= kill_new;
            coll_overrun  <= 1'b0;
          end
        end
        PEND: begin
          if (accept) begin
            if (any_new) begin
              coll_valid    <= 1'b1;
              coll_eat_mask <= eat_new;
              coll_kill     <= kill_new;
              coll_overrun  <= 1'b0;
            end else begin
              rpt_state     <= IDLE;
              coll_valid    <= 1'b0;
              coll_eat_mask <= '0;
              coll_kill     <= 1'b0;
              coll_overrun  <= 1'b0;
            end
          end else if (any_new) begin
            coll_eat_mask <= coll_eat_mask | eat_new;
            coll_kill     <= coll_kill | kill_new;
            coll_overrun  <= 1'b1;
          end
        end
        default: begin
          rpt_state  <= IDLE;
          coll_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef COLL_STATS_EN
  // Accepted-report counter, sticks at all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reports <= 16'd0;
    end else if (accept && (stat_reports != 16'hFFFF)) begin
      stat_reports <= stat_reports + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ghost_collision_detector.sv
// Directed bench for ghost_collision_detector (MIN_OVERLAP = 4).
// Pixel coordinates are driven directly so each frame is only a few cycles.
module tb_ghost_collision_detector;
  import ghost_collision_detector_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pixel_tick;
  logic               video_on;
  logic [9:0]         h_count;
  logic [9:0]         v_count;
  logic               pacman_drawing;
  logic [3:0]         ghost_drawing;
  ghost_modes_t [3:0] ghost_state;
  logic               coll_valid;
  logic               coll_ready;
  logic [3:0]         coll_eat_mask;
  logic               coll_kill;
  logic               coll_overrun;
`ifdef COLL_STATS_EN
  logic [15:0]        stat_reports;
`endif

  int checks = 0;
  int errors = 0;
  int exp_stats = 0;

  ghost_collision_detector #(
    .NUM_GHOSTS (4),
    .MIN_OVERLAP(4),
    .H_ACTIVE   (640),
    .V_ACTIVE   (480)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pixel_tick    (pixel_tick),
    .video_on      (video_on),
    .h_count       (h_count),
    .v_count       (v_count),
    .pacman_drawing(pacman_drawing),
    .ghost_drawing (ghost_drawing),
    .ghost_state   (ghost_state),
    .coll_valid    (coll_valid),
    .coll_ready    (coll_ready),
    .coll_eat_mask (coll_eat_mask),
    .coll_kill     (coll_kill),
    .coll_overrun  (coll_overrun)
`ifdef COLL_STATS_EN
    ,
    .stat_reports  (stat_reports)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_report(input string tag, input logic v, input logic [3:0] m,
                              input logic k, input logic o);
    check_output({tag, " valid"}, 32'(coll_valid), 32'(v));
    check_output({tag, " mask"}, 32'(coll_eat_mask), 32'(m));
    check_output({tag, " kill"}, 32'(coll_kill), 32'(k));
    check_output({tag, " overrun"}, 32'(coll_overrun), 32'(o));
  endtask

  // One pixel presented for one clock; outputs are settled when this returns.
  task automatic apply_stimulus(input logic [9:0] h, input logic [9:0] v, input logic pac,
                                input logic [3:0] ghosts, input logic tick, input logic von);
    h_count        = h;
    v_count        = v;
    pacman_drawing = pac;
    ghost_drawing  = ghosts;
    pixel_tick     = tick;
    video_on       = von;
    @(posedge clk);
    #1;
    pixel_tick     = 1'b0;
    pacman_drawing = 1'b0;
    ghost_drawing  = 4'b0000;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // SOF pixel (no overlap) followed by n overlapping pixels on line 10.
  task automatic frame_body(input logic [3:0] gmask, input int n);
    apply_stimulus(10'd0, 10'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(10'(i + 1), 10'd10, 1'b1, gmask, 1'b1, 1'b1);
    end
  endtask

  task automatic frame_eof(input logic [3:0] gmask, input logic rdy);
    coll_ready = rdy;
    apply_stimulus(10'd639, 10'd479, |gmask, gmask, 1'b1, 1'b1);
    coll_ready = 1'b0;
  endtask

  task automatic accept_report();
    coll_ready = 1'b1;
    @(posedge clk);
    #1;
    coll_ready = 1'b0;
    exp_stats++;
  endtask

  task automatic all_chase();
    for (int i = 0; i < 4; i++) ghost_state[i] = CHASE;
  endtask

  initial begin
    reset_n        = 1'b0;
    pixel_tick     = 1'b0;
    video_on       = 1'b0;
    h_count        = 10'd0;
    v_count        = 10'd0;
    pacman_drawing = 1'b0;
    ghost_drawing  = 4'b0000;
    coll_ready     = 1'b0;
    all_chase();
    #23;
    check_report("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    idle_cycles(2);

    // Pre-SOF pixels are ignored: 3 before + 3 after is below threshold.
    for (int i = 0; i < 3; i++) apply_stimulus(10'(20 + i), 10'd100, 1'b1, 4'b0001, 1'b1, 1'b1);
    frame_body(4'b0001, 3);
    frame_eof(4'b0000, 1'b0);
    check_output("presof_ignored valid", 32'(coll_valid), 32'd0);

    // Reset mid-frame, then 3 pre-SOF + 5 counted pixels -> ghost0 kill.
    frame_body(4'b0001, 2);
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    exp_stats = 0;
    idle_cycles(1);
    check_report("midreset", 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(10'(20 + i), 10'd100, 1'b1, 4'b0001, 1'b1, 1'b1);
    frame_body(4'b0001, 5);
    frame_eof(4'b0000, 1'b0);
    check_report("ghost0_kill", 1'b1, 4'b0000, 1'b1, 1'b0);
    accept_report();
    check_report("ghost0_retired", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Ghost1 CHASE, 4 pixels: valid appears only after the EOF edge.
    frame_body(4'b0010, 4);
    check_output("ghost1_pre_eof valid", 32'(coll_valid), 32'd0);
    frame_eof(4'b0000, 1'b0);
    check_report("ghost1_kill", 1'b1, 4'b0000, 1'b1, 1'b0);
    accept_report();

    // Ghost2 AFFRAID: 3 pixels is not a hit, 4 pixels is an eat.
    ghost_state[2] = AFFRAID;
    frame_body(4'b0100, 3);
    frame_eof(4'b0000, 1'b0);
    check_output("ghost2_3px valid", 32'(coll_valid), 32'd0);
    frame_body(4'b0100, 4);
    frame_eof(4'b0000, 1'b0);
    check_report("ghost2_eat", 1'b1, 4'b0100, 1'b0, 1'b0);
    accept_report();

    // The EOF pixel itself counts: 3 + overlapping EOF pixel = hit.
    frame_body(4'b0100, 3);
    frame_eof(4'b0100, 1'b0);
    check_report("eof_counts", 1'b1, 4'b0100, 1'b0, 1'b0);
    accept_report();

    // Two EOFs with no accept: masks merge and overrun flags.
    ghost_state[3] = AFFRAID;
    frame_body(4'b0100, 4);
    frame_eof(4'b0000, 1'b0);
    check_report("ovr_first", 1'b1, 4'b0100, 1'b0, 1'b0);
    frame_body(4'b1000, 4);
    frame_eof(4'b0000, 1'b0);
    check_report("ovr_merged", 1'b1, 4'b1100, 1'b0, 1'b1);
    idle_cycles(3);
    check_report("ovr_stable", 1'b1, 4'b1100, 1'b0, 1'b1);
    accept_report();
    check_report("ovr_retired", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Accept on the EOF edge: old eat retired, new ghost0 kill loaded.
    frame_body(4'b0100, 4);
    frame_eof(4'b0000, 1'b0);
    check_report("coinc_old", 1'b1, 4'b0100, 1'b0, 1'b0);
    frame_body(4'b0001, 4);
    frame_eof(4'b0000, 1'b1);
    exp_stats++;
    check_report("coinc_new", 1'b1, 4'b0000, 1'b1, 1'b0);
    accept_report();
    check_report("coinc_retired", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Ghost1 EATEN overlapping 20 pixels never reports.
    all_chase();
    ghost_state[1] = EATEN;
    frame_body(4'b0010, 20);
    frame_eof(4'b0000, 1'b0);
    check_output("eaten valid", 32'(coll_valid), 32'd0);

    // Pixels without video_on or pixel_tick do not count.
    all_chase();
    frame_body(4'b0001, 3);
    for (int i = 0; i < 4; i++) apply_stimulus(10'(50 + i), 10'd20, 1'b1, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(10'(60 + i), 10'd20, 1'b1, 4'b0001, 1'b0, 1'b1);
    frame_eof(4'b0000, 1'b0);
    check_output("gating valid", 32'(coll_valid), 32'd0);

    // Eat and kill in the same frame are both reported.
    ghost_state[3] = AFFRAID;
    frame_body(4'b1001, 4);
    frame_eof(4'b0000, 1'b0);
    check_report("eat_and_kill", 1'b1, 4'b1000, 1'b1, 1'b0);
    accept_report();
    check_report("final_idle", 1'b0, 4'b0000, 1'b0, 1'b0);

`ifdef COLL_STATS_EN
    check_output("stat_reports", 32'(stat_reports), 32'(exp_stats));
`endif

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
